mul_div_post: RTL

// - Result post-processing stage directly downstream of the multi-cycle mul/div unit.
// - Takes the unsigned magnitude result and the original operand signs.
// - Applies two's-complement sign correction.
// - Selects the 32-bit word chosen by the one-hot op.
// - Buffers results in a small FIFO with a valid/ready handshake toward writeback, so
//   a downstream stall never drops a finished multiply/divide.

---
 rtl/mul_div_post.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_post.sv
// mul_div_post -- result post-processing stage behind the multi-cycle mul/div unit.
//
// Takes the unsigned magnitude result and the original operand signs. It applies
// two's-complement sign correction and selects the 32-bit word requested by the
// one-hot op. The corrected word and its tag are then buffered in a small FIFO
// with a valid/ready handshake toward writeback.
//
// Parameters:
//   DEPTH  result FIFO entries (power of two, >= 2)
//   TAGW   destination-register tag width
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   flush      synchronous flush, empties the FIFO
//   in_valid   result from mul/div unit valid
//   in_ready   stage can accept a result (registered state only)
//   in_op      one-hot: [0] mul lo, [1] mul hi, [2] quotient, [3] remainder
//   in_sign    signed operation
//   in_a_neg   operand a was negative
//   in_b_neg   operand b was negative
//   in_result  magnitude: {hi,lo} product or {remainder,quotient}
//   in_tag     destination register tag
//   out_valid  FIFO head valid
//   out_ready  writeback accepts head
//   out_data   corrected 32-bit result
//   out_tag    tag of head entry
//
// Configuration macro: MUL_DIV_POST_BYPASS_EN
//   When defined, an empty FIFO with in_valid & out_ready forwards the corrected
//   input combinationally (0-cycle latency) without writing it.
module mul_div_post #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic            in_sign,
  input  logic            in_a_neg,
  input  logic            in_b_neg,
  input  logic [63:0]     in_result,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [TAGW-1:0] out_tag
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Sign correction
  logic        neg_q;
  logic        neg_r;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] corr_data;

  assign neg_q = in_sign & (in_a_neg ^ in_b_neg);
  assign neg_r = in_sign & in_a_neg;
  // Full 64-bit negate so the carry out of the low word reaches the high word.
  assign prod  = neg_q ? (~in_result + 64'd1) : in_result;
  assign quo   = neg_q ? (~in_result[31:0] + 32'd1) : in_result[31:0];
  assign rem   = neg_r ? (~in_result[63:32] + 32'd1) : in_result[63:32];

  always_comb begin
    corr_data = '0;
    if (in_op[0])      corr_data = prod[31:0];
    else if (in_op[1]) corr_data = prod[63:32];
    else if (in_op[2]) corr_data = quo;
    else if (in_op[3]) corr_data = rem;
  end

  // FIFO state
  logic [31:0]     mem_data_q [DEPTH];
  logic [TAGW-1:0] mem_tag_q  [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     head_data_q, head_data_d;
  logic [TAGW-1:0] head_tag_q, head_tag_d;

  logic          count_nz;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [PW-1:0] rd_nxt;

  assign count_nz = (count_q != '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign rd_nxt   = rd_ptr_q + PW'(1);

`ifdef MUL_DIV_POST_BYPASS_EN
  assign bypass = ~count_nz & in_valid & out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = count_nz | bypass;
  assign out_data  = bypass ? corr_data : head_data_q;
  assign out_tag   = bypass ? in_tag    : head_tag_q;

  assign push = in_valid & in_ready & ~bypass;
  assign pop  = count_nz & out_ready;

  // The head is kept in its own register so out_data/out_tag reset to zero and
  // hold the last popped entry while the FIFO is empty.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_nxt;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (pop) begin
        if (count_q >= CW'(2)) begin
          head_data_d = mem_data_q[rd_nxt];
          head_tag_d  = mem_tag_q[rd_nxt];
        end else if (push) begin
          head_data_d = corr_data;
          head_tag_d  = in_tag;
        end
      end else if (!count_nz && push) begin
        head_data_d = corr_data;
        head_tag_d  = in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_tag_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_data_q[wr_ptr_q] <= corr_data;
      mem_tag_q[wr_ptr_q]  <= in_tag;
    end
  end

endmodule
